// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - MEM-stage load/store controller bridging the pipeline to a req/gnt/rvalid bus
module mem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rmem_en_i,
    input  logic        mem_wmem_en_i,
    input  logic [31:0] mem_addr_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [31:0] mem_wdata_i,
    output logic        hold_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    addr_lo;
    logic [2:0]    funct3_q;

    logic        one_en;
    logic        f3_legal;
    logic        aligned;
    logic        access;
    logic        illegal;
    logic        misaligned;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] fmt_rdata;
    logic        granted_rd;
    logic        complete_wr;
    logic        complete_rd;

    // Request decode and store lane steering, only meaningful while IDLE
    always_comb begin
        one_en = mem_rmem_en_i ^ mem_wmem_en_i;
        if (mem_rmem_en_i) begin
            f3_legal = mem_funct3_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        end else begin
            f3_legal = mem_funct3_i inside {3'd0, 3'd1, 3'd2};
        end
        case (mem_funct3_i[1:0])
            2'd1:    aligned = ~mem_addr_i[0];
            2'd2:    aligned = (mem_addr_i[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        access     = one_en & f3_legal & aligned;
        illegal    = (mem_rmem_en_i & mem_wmem_en_i) | (one_en & ~f3_legal);
        misaligned = one_en & f3_legal & ~aligned;
        case (mem_funct3_i[1:0])
            2'd0: begin
                fmt_be    = 4'b0001 << mem_addr_i[1:0];
                fmt_wdata = {4{mem_wdata_i[7:0]}};
            end
            2'd1: begin
                fmt_be    = 4'b0011 << {mem_addr_i[1], 1'b0};
                fmt_wdata = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                fmt_be    = 4'b1111;
                fmt_wdata = mem_wdata_i;
            end
        endcase
    end

    always_comb begin
        rd_byte = bus_rdata_i[{addr_lo, 3'b000} +: 8];
        rd_half = addr_lo[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (funct3_q)
            3'd0:    fmt_rdata = {{24{rd_byte[7]}}, rd_byte};
            3'd4:    fmt_rdata = {24'd0, rd_byte};
            3'd1:    fmt_rdata = {{16{rd_half[15]}}, rd_half};
            3'd5:    fmt_rdata = {16'd0, rd_half};
            default: fmt_rdata = bus_rdata_i;
        endcase
    end

    // A read counts as granted in WAIT or when the grant arrives this cycle in REQ
    assign granted_rd  = (state == WAIT) | ((state == REQ) & bus_gnt_i);
    assign complete_wr = (state == REQ) & bus_gnt_i & bus_we_o;
    assign complete_rd = granted_rd & ~bus_we_o & bus_rvalid_i;

    assign hold_o = ~rst & (((state == IDLE) & access) | (state == REQ) | (state == WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_lo      <= 2'b00;
            funct3_q     <= 3'd0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= 32'd0;
            bus_be_o     <= 4'd0;
            bus_wdata_o  <= 32'd0;
            load_data_o  <= 32'd0;
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            load_valid_o <= 1'b0;
            misalign_o   <= 1'b0;
            err_o        <= 1'b0;
            case (state)
                IDLE: begin
                    if (access) begin
                        addr_lo     <= mem_addr_i[1:0];
                        funct3_q    <= mem_funct3_i;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_we_o    <= mem_wmem_en_i;
                        bus_be_o    <= fmt_be;
                        bus_wdata_o <= fmt_wdata;
                        bus_req_o   <= 1'b1;
                        cnt         <= '0;
                        state       <= REQ;
                    end else if (illegal) begin
                        err_o <= 1'b1;
                    end else if (misaligned) begin
                        misalign_o <= 1'b1;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (complete_wr || complete_rd) begin
                        bus_req_o <= 1'b0;
                        state     <= DONE;
                        if (complete_rd) begin
                            load_data_o  <= fmt_rdata;
                            load_valid_o <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= DONE;
                    end else if ((state == REQ) && bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state     <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: bus cycles allowed in REQ+WAIT before an access is aborted.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_rmem_en_i / mem_wmem_en_i  in  1 each  load / store request from the MEM-stage pipeline register.
REQ-005 mem_addr_i  in  32  byte address; mem_funct3_i  in  3  access size/sign (RV32I encoding).
REQ-006 mem_wdata_i  in  32  store data, right-justified.
REQ-007 hold_o  out  1  stall for IF/ID/EX/EX-MEM pipeline registers.
REQ-008 bus_req_o, bus_we_o  out  1 each; bus_addr_o  out  32  word-aligned; bus_be_o  out  4; bus_wdata_o  out  32.
REQ-009 bus_gnt_i, bus_rvalid_i  in  1 each; bus_rdata_i  in  32.
REQ-010 load_data_o  out  32  aligned/extended load result; load_valid_o  out  1; misalign_o  out  1; err_o  out  1.

Function
REQ-011 States: IDLE, REQ, WAIT, DONE; encoding is free.
REQ-012 "Access" = exactly one of rmem_en/wmem_en high, funct3 legal (loads 0,1,2,4,5; stores 0,1,2), address aligned (half: addr[0]=0; word: addr[1:0]=0).
REQ-013 IDLE with access: capture addr, funct3, we, and lane-formatted wdata/be; next state REQ; hold_o high combinationally in that same cycle.
REQ-014 IDLE with both enables high or illegal funct3: err_o pulses high in the next cycle; no bus activity; no hold.
REQ-015 IDLE with legal but misaligned request: misalign_o pulses high in the next cycle; no bus activity; no hold.
REQ-016 REQ: bus_req_o=1; on bus_gnt_i, a write goes to DONE, a read goes to WAIT, and a read with bus_rvalid_i also high in the same cycle goes straight to DONE.
REQ-017 WAIT: on bus_rvalid_i, capture the formatted rdata into load_data_o and go to DONE.
REQ-018 DONE: hold_o=0 for exactly one cycle; load_valid_o=1 for a completed read; next state IDLE.
REQ-019 hold_o = 1 throughout REQ and WAIT; the pipeline advances at the DONE edge.
REQ-020 bus_addr_o = {captured addr[31:2],2'b00}; bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are stable while bus_req_o=1.
REQ-021 Store lanes: SB be=4'b0001<<addr[1:0], wdata=byte replicated x4.
REQ-022 Store lanes: SH be=4'b0011<<{addr[1],1'b0}, wdata=half replicated x2.
REQ-023 Store lanes: SW be=4'b1111.
REQ-024 Load format: LB/LBU select byte addr[1:0], sign-/zero-extended.
REQ-025 Load format: LH/LHU select half addr[1], sign-/zero-extended.
REQ-026 Load format: LW passes the word unchanged.
REQ-027 load_data_o holds its value until the next completed read.
REQ-028 Timeout counter clears on entry to REQ and counts each cycle in REQ/WAIT.
REQ-029 When the counter reaches TIMEOUT-1 without completion, go to DONE with err_o=1, load_valid_o=0 and load_data_o unchanged.
REQ-030 bus_gnt_i/bus_rvalid_i are ignored in IDLE and DONE.
REQ-031 Inputs mem_* are sampled only in IDLE.

Reset
REQ-032 Reset forces state IDLE, counter 0, and every output to 0 (hold_o, bus_*, load_data_o, load_valid_o, misalign_o, err_o).
REQ-033 Reset asserted mid-access (REQ/WAIT) abandons the access: bus_req_o=0 and hold_o=0 in the first cycle after reset, and no load_valid_o for it.

Verification
REQ-034 LW addr 0x100: gnt after 2 cycles, rvalid 1 cycle later with 0xDEADBEEF -> bus_addr_o=0x100, load_data_o=0xDEADBEEF, one load_valid_o pulse, hold_o high 4 cycles.
REQ-035 LB addr 0x103 and LBU addr 0x103 with rdata 0x80112233 -> 0xFFFFFF80 and 0x00000080 respectively.
REQ-036 SH addr 0x202, wdata 0x0000ABCD, immediate gnt -> bus_be_o=4'b1100, bus_wdata_o=0xABCDABCD, bus_we_o=1, no load_valid_o.
REQ-037 LW addr 0x101 -> misalign_o pulse, bus_req_o stays 0, hold_o stays 0.
REQ-038 Read with gnt but no rvalid, TIMEOUT=16 -> err_o pulse, hold_o released after 16 stalled cycles, load_data_o unchanged.
REQ-039 Reset asserted in WAIT -> next cycle state IDLE with all outputs 0; a following SW completes normally.
